// File: rtl/shift_seq_pkg.sv
// Shared types for the shift/load sequencer: FSM state encoding and width helpers.
package shift_seq_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } seq_state_e;

    // Shift-cycle down-counter width; LENGTH is at least 2, so this is never zero.
    function automatic int unsigned cnt_width(input int unsigned length);
        return (length < 2) ? 1 : $clog2(length);
    endfunction

endpackage

// File: rtl/shift_seq_skid.sv
// One-entry holding buffer that lets the sequencer accept the next word while one is shifting.
module shift_seq_skid
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] buf_data,
    output logic             buf_valid
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // Push only happens while empty and pop only while full, so they never collide.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (pop) begin
            valid_d = 1'b0;
        end
        if (push) begin
            valid_d = 1'b1;
            data_d  = push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign buf_data  = data_q;
    assign buf_valid = valid_q;

endmodule

// File: rtl/shift_load_sequencer.sv
// Drives a downstream parallel-load shift register: one LOAD cycle then LENGTH-1 SHIFT cycles per word.
// Define SEQ_SKID_EN for a one-entry holding buffer giving gapless back-to-back words.
module shift_load_sequencer
    import shift_seq_pkg::*;
#(
    parameter int unsigned LENGTH = 4,
    parameter bit          FILL   = 1'b0
) (
    input  logic              CP,
    input  logic              MR,
    input  logic [LENGTH-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              PE,
    output logic [LENGTH-1:0] P,
    output logic              J,
    output logic              K,
    output logic              word_start,
    output logic              busy
);

    localparam int unsigned       CNT_W    = cnt_width(LENGTH);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(LENGTH - 2);

    seq_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LENGTH-1:0] cur_q, cur_d;
    logic              pe_q, pe_d;
    logic              ws_q, ws_d;
    logic              busy_q, busy_d;
    logic              xfer;

`ifdef SEQ_SKID_EN
    logic              buf_push;
    logic              buf_pop;
    logic              buf_valid;
    logic [LENGTH-1:0] buf_data;

    shift_seq_skid #(
        .WIDTH(LENGTH)
    ) u_skid (
        .clk       (CP),
        .rst       (MR),
        .push      (buf_push),
        .push_data (in_data),
        .pop       (buf_pop),
        .buf_data  (buf_data),
        .buf_valid (buf_valid)
    );

    assign in_ready = ~buf_valid;
`else
    assign in_ready = (state_q == IDLE);
`endif

    assign xfer = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
`ifdef SEQ_SKID_EN
        buf_push = 1'b0;
        buf_pop  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    cur_d   = in_data;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = SHIFT;
                cnt_d   = CNT_INIT;
`ifdef SEQ_SKID_EN
                buf_push = xfer;
`endif
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
`ifdef SEQ_SKID_EN
                    buf_push = xfer;
`endif
                end else begin
`ifdef SEQ_SKID_EN
                    // A word taken on the final shift edge bypasses the empty buffer.
                    if (buf_valid) begin
                        cur_d   = buf_data;
                        buf_pop = 1'b1;
                        state_d = LOAD;
                    end else if (xfer) begin
                        cur_d   = in_data;
                        state_d = LOAD;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        pe_d   = (state_d == LOAD);
        ws_d   = (state_d == LOAD);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CP or posedge MR) begin
        if (MR) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cur_q   <= '0;
            pe_q    <= 1'b0;
            ws_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            pe_q    <= pe_d;
            ws_q    <= ws_d;
            busy_q  <= busy_d;
        end
    end

    assign PE         = pe_q;
    assign word_start = ws_q;
    assign busy       = busy_q;
    assign P          = cur_q;
    assign J          = FILL;
    assign K          = ~FILL;

endmodule

// File: doc/shift_load_sequencer.md
SHIFT_LOAD_SEQUENCER -- requirements
Module: shift_load_sequencer

Interface
REQ-001 Parameter LENGTH, default 4: shift-register width in bits; legal range 2..16.
REQ-002 Parameter FILL, default 0: serial fill bit shifted into stage 0 during shift cycles.
REQ-003 CP  input  1: single clock; all state changes on the rising edge.
REQ-004 MR  input  1: asynchronous, active-high reset.
REQ-005 in_data  input  LENGTH: parallel word offered by the producer.
REQ-006 in_valid  input  1: in_data is valid.
REQ-007 in_ready  output  1: the sequencer accepts in_data on this edge.
REQ-008 PE  output  1: downstream register mode; 1 = parallel load of P, 0 = shift.
REQ-009 P  output  LENGTH: word presented for parallel load.
REQ-010 J  output  1: serial J input to downstream stage 0.
REQ-011 K  output  1: serial K input to downstream stage 0.
REQ-012 word_start  output  1: one-cycle pulse in each load cycle.
REQ-013 busy  output  1: a word is loading or shifting.

Function
REQ-014 A transfer occurs on an edge where in_valid=1 and in_ready=1; in_data is captured into an internal current-word register.
REQ-015 States: IDLE, LOAD, SHIFT.
  - IDLE: PE=0, busy=0.
  - LOAD: PE=1, P=current word, word_start=1, busy=1.
  - SHIFT: PE=0, busy=1.
REQ-016 IDLE -> LOAD on the edge after a transfer; the load cycle is exactly one CP cycle.
REQ-017 LOAD -> SHIFT. SHIFT lasts exactly LENGTH-1 cycles, tracked by a down-counter of width clog2(LENGTH) that is loaded with LENGTH-2 on entry to SHIFT.
REQ-018 From the final SHIFT cycle (counter=0): go to LOAD if a word is pending, else to IDLE.
REQ-019 Each word occupies exactly LENGTH cycles (1 load + LENGTH-1 shifts); the downstream last-stage output presents P[LENGTH-1] first and P[0] last.
REQ-020 J=FILL and K=~FILL at all times, so each shift writes FILL into stage 0; J and K are don't-care in load cycles but are held constant anyway.
REQ-021 P holds the current word in every state and changes only on a LOAD entry; P=0 until the first load.
REQ-022 in_ready rules:
  - Without SEQ_SKID_EN: in_ready=1 only in IDLE.
  - With SEQ_SKID_EN: in_ready=1 whenever the holding buffer is empty.
REQ-023 in_ready is registered-state-derived only; it has no combinational path from in_valid.
REQ-024 If in_valid drops without a transfer, the sequencer stays in IDLE indefinitely, with outputs stable.

Reset
REQ-025 While MR=1, asynchronously: state=IDLE, counter=0, current word=0, holding buffer empty.
REQ-026 Reset outputs: PE=0, P=0, word_start=0, busy=0, J=FILL, K=~FILL, in_ready=1.
REQ-027 MR asserted mid-word aborts that word and discards any pending word; after MR deasserts, the first clock edge may accept a transfer.

Configuration
REQ-028 Macro SEQ_SKID_EN.
  - Defined: a one-entry holding buffer accepts the next word during LOAD/SHIFT. On the final SHIFT cycle the buffer moves into the current word, the FSM goes directly to LOAD (gapless back-to-back words), and the buffer frees in the same edge.
  - Undefined: no buffer, and one IDLE cycle minimum occurs between consecutive words.

Structure
REQ-029 Package shift_seq_pkg holds the state enumeration (IDLE, LOAD, SHIFT) and the state-width constant.
REQ-030 One sub-module, shift_seq_skid, holds the buffer register and its valid flag; it is instantiated only under SEQ_SKID_EN.

Verification
REQ-031 Reset: MR=1 mid-SHIFT, LENGTH=4 -> outputs go to the REQ-026 values immediately; the next word starts cleanly after release.
REQ-032 Single word: in_data=4'b1011, one transfer, with the bench model of the downstream 4-bit register attached -> word_start once; PE=1,0,0,0; last stage shows 1,0,1,1; then IDLE.
REQ-033 Back-to-back, SEQ_SKID_EN defined: in_valid held high with 4'hA then 4'h5 -> second LOAD occurs exactly 4 cycles after the first; serial stream 1010_0101 with no gap.
REQ-034 Back-to-back, SEQ_SKID_EN undefined: same stimulus as REQ-033 -> second LOAD occurs 5 cycles after the first, and in_ready=0 during the busy cycles.
REQ-035 FILL=1, LENGTH=4, in_data=4'h0 -> J=1, K=0; downstream register reads 4'b0111 after the third shift.
REQ-036 Backpressure: in_valid pulsed while busy with the buffer full -> no transfer; in_data is not corrupted and is accepted once in_ready rises.
